// File: rtl/addition_pkg.sv
// Shared widths and status flags for the FP-add normalization stage.
package addition_pkg;
  localparam int MENT_WIDTH_DEF = 23;
  localparam int EXPO_WIDTH_DEF = 8;
  localparam int GUARD_BITS_DEF = 3;

  // Sum layout is {carry, hidden, fraction, guard}.
  function automatic int sum_width(input int ment_w, input int guard_b);
    return ment_w + guard_b + 2;
  endfunction

  localparam int SUM_W_DEF = sum_width(MENT_WIDTH_DEF, GUARD_BITS_DEF);

  typedef struct packed {
    logic zero;
    logic overflow;
    logic underflow;
  } status_t;
endpackage

// File: rtl/leading_zero_counter.sv
// Combinational priority encoder: number of zeros above the highest set bit.
module leading_zero_counter #(
  parameter int W  = 27,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  in_i,
  output logic [CW-1:0] cnt_o
);
  // Ascending scan: the highest set bit is written last and wins.
  always_comb begin
    cnt_o = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (in_i[i]) cnt_o = CW'(W - 1 - i);
    end
  end
endmodule

// File: rtl/addition_normalizer_pipe.sv
// Two-stage normalizer for an FP adder: S1 captures the sum plus its leading-zero
// count, S2 shifts/adjusts the exponent and raises zero/overflow/underflow.
module addition_normalizer_pipe
  import addition_pkg::*;
#(
  parameter int MENT_WIDTH = MENT_WIDTH_DEF,
  parameter int EXPO_WIDTH = EXPO_WIDTH_DEF,
  parameter int GUARD_BITS = GUARD_BITS_DEF,
  localparam int SUM_W     = sum_width(MENT_WIDTH, GUARD_BITS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_sign,
  input  logic [EXPO_WIDTH-1:0] in_exponent,
  input  logic [SUM_W-1:0]      in_sum,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_sign,
  output logic [EXPO_WIDTH-1:0] out_exponent,
  output logic [SUM_W-2:0]      out_mantissa,
  output logic                  out_zero,
  output logic                  out_overflow,
  output logic                  out_underflow
);
  localparam int MAN_W = SUM_W - 1;
  localparam int LZ_W  = $clog2(SUM_W);
  localparam int XW    = EXPO_WIDTH + 1;

  logic [2:1]            vld_q;
  logic                  s1_sign_q;
  logic [EXPO_WIDTH-1:0] s1_exp_q;
  logic [SUM_W-1:0]      s1_sum_q;
  logic [LZ_W-1:0]       s1_lz_q;
  logic [LZ_W-1:0]       lz;

  logic                  sign_q;
  logic [EXPO_WIDTH-1:0] exp_q, exp_d;
  logic [MAN_W-1:0]      mant_q, mant_d;
  status_t               flags_q, flags_d;

  logic s1_ready, s2_ready;
  assign s2_ready = !vld_q[2] || out_ready;
  assign s1_ready = !vld_q[1] || s2_ready;
  assign in_ready = !rst && s1_ready;

  leading_zero_counter #(.W(MAN_W), .CW(LZ_W)) u_lzc (
    .in_i  (in_sum[MAN_W-1:0]),
    .cnt_o (lz)
  );

  // Exponent math is one bit wider so +1 and compares never wrap.
  logic [XW-1:0] exp_x, lz_x, inc_x, shamt_x;
  assign exp_x   = {1'b0, s1_exp_q};
  assign lz_x    = XW'(s1_lz_q);
  assign inc_x   = exp_x + XW'(1);
  assign shamt_x = (exp_x == '0) ? '0 : exp_x - XW'(1);

  always_comb begin
    mant_d  = s1_sum_q[MAN_W-1:0];
    exp_d   = s1_exp_q;
    flags_d = '0;
    if (&s1_exp_q) begin
      // Inf/NaN: pass through untouched
    end else if (s1_sum_q[SUM_W-1]) begin
      if (inc_x == {1'b0, {EXPO_WIDTH{1'b1}}}) begin
        exp_d            = '1;
        mant_d           = '0;
        flags_d.overflow = 1'b1;
      end else begin
        exp_d  = inc_x[EXPO_WIDTH-1:0];
        mant_d = s1_sum_q[SUM_W-1:1] | MAN_W'(s1_sum_q[0]);
      end
    end else if (s1_sum_q == '0) begin
      exp_d        = '0;
      mant_d       = '0;
      flags_d.zero = 1'b1;
    end else if (lz_x < exp_x) begin
      // lz < exponent, so this subtraction cannot go below 1
      mant_d = s1_sum_q[MAN_W-1:0] << s1_lz_q;
      exp_d  = s1_exp_q - EXPO_WIDTH'(s1_lz_q);
    end else begin
      mant_d            = s1_sum_q[MAN_W-1:0] << shamt_x;
      exp_d             = '0;
      flags_d.underflow = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q     <= '0;
      s1_sign_q <= 1'b0;
      s1_exp_q  <= '0;
      s1_sum_q  <= '0;
      s1_lz_q   <= '0;
      sign_q    <= 1'b0;
      exp_q     <= '0;
      mant_q    <= '0;
      flags_q   <= '0;
    end else begin
      if (s1_ready) begin
        vld_q[1] <= in_valid;
        if (in_valid) begin
          s1_sign_q <= in_sign;
          s1_exp_q  <= in_exponent;
          s1_sum_q  <= in_sum;
          s1_lz_q   <= lz;
        end
      end
      if (s2_ready) begin
        vld_q[2] <= vld_q[1];
        if (vld_q[1]) begin
          sign_q  <= s1_sign_q;
          exp_q   <= exp_d;
          mant_q  <= mant_d;
          flags_q <= flags_d;
        end
      end
    end
  end

  assign out_valid     = vld_q[2];
  assign out_sign      = sign_q;
  assign out_exponent  = exp_q;
  assign out_mantissa  = mant_q;
  assign out_zero      = flags_q.zero;
  assign out_overflow  = flags_q.overflow;
  assign out_underflow = flags_q.underflow;
endmodule

// File: doc/addition_normalizer_pipe.md
ADDITION_NORMALIZER_PIPE -- requirements
Module: addition_normalizer_pipe

Interface
REQ-001 SHALL have parameter MENT_WIDTH, default 23, meaning stored fraction bits (hidden bit excluded).
REQ-002 SHALL have parameter EXPO_WIDTH, default 8, meaning biased exponent bits.
REQ-003 SHALL have parameter GUARD_BITS, default 3, meaning extra low-order bits carried below the fraction LSB for rounding.
REQ-004 SHALL define the derived width SUM_W = MENT_WIDTH+GUARD_BITS+2, laid out as {carry, hidden, fraction, guard}.
REQ-005 SHALL use one clock and a synchronous, active-high reset.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 in_valid  input  1  upstream data valid.
REQ-009 in_ready  output  1  block accepts input this cycle.
REQ-010 in_sign  input  1  result sign, passed through.
REQ-011 in_exponent  input  EXPO_WIDTH  bigger exponent from the exponent-compare stage.
REQ-012 in_sum  input  SUM_W  raw mantissa sum from the mantissa-add stage.
REQ-013 out_valid  output  1  normalized result valid.
REQ-014 out_ready  input  1  downstream (rounding stage) accepts the result.
REQ-015 out_sign  output  1  registered sign.
REQ-016 out_exponent  output  EXPO_WIDTH  normalized exponent.
REQ-017 out_mantissa  output  SUM_W-1  {hidden, fraction, guard}, with the lowest bit acting as sticky.
REQ-018 out_zero, out_overflow, out_underflow  output  1 each  status flags.

Function
REQ-019 SHALL be a 2-stage pipeline: S1 registers the inputs plus a leading-zero count of in_sum[SUM_W-2:0]; S2 registers the shifted result and flags.
- Latency: 2 cycles from accept to out_valid.
- Throughput: 1 result per cycle.
REQ-020 Each stage SHALL advance when it is empty or the next stage advances; in_ready = !s1_valid || s1_advance.
REQ-021 While out_valid=1 and out_ready=0, all outputs SHALL hold stable, and no accepted item SHALL be dropped or reordered.
REQ-022 If in_exponent is all ones (Inf/NaN), the input SHALL pass through unshifted with no flags set.
REQ-023 If the carry bit is set, the sum SHALL be shifted right by 1 and the exponent incremented.
- The shifted-out bit SHALL be ORed into the output LSB (sticky).
REQ-024 If the incremented exponent equals all ones, the block SHALL output out_exponent=all ones, out_mantissa=0 and out_overflow=1.
REQ-025 If the sum is zero, the block SHALL output out_zero=1, out_exponent=0 and out_mantissa=0.
REQ-026 If the leading-zero count lz < in_exponent, the sum SHALL be shifted left by lz and lz subtracted from the exponent.
REQ-027 If lz >= in_exponent, the sum SHALL be shifted left by max(in_exponent-1,0), with out_exponent=0 and out_underflow=1 (denormal result).
REQ-028 Exponent arithmetic SHALL be computed EXPO_WIDTH+1 bits wide, so no intermediate wraps.
- At most one of out_zero, out_overflow, out_underflow SHALL be set at a time.

Reset
REQ-029 On rst=1 at a clock edge, both stage valids SHALL clear and every output register SHALL become 0.
- This includes out_valid, out_sign, out_exponent, out_mantissa and all flags.
REQ-030 in_ready SHALL be 0 while rst=1 and 1 in the first cycle after reset deasserts.
REQ-031 Reset asserted mid-stream SHALL discard all in-flight items, with out_valid=0 from the next cycle.

Structure
REQ-032 Package addition_pkg SHALL hold the default MENT_WIDTH/EXPO_WIDTH/GUARD_BITS values, the SUM_W derivation and the status-flag struct.
REQ-033 Sub-module leading_zero_counter SHALL be a parametrised combinational priority encoder, instantiated in S1.

Verification (MENT_WIDTH=23, EXPO_WIDTH=8, GUARD_BITS=3, SUM_W=28)
REQ-034 Carry case: in_sum=28'h8000001, exp=127 -> 2 cycles later out_exponent=128, out_mantissa=27'h4000001, no flags.
REQ-035 Left normalize: in_sum=28'h0100000, exp=127 -> out_exponent=121, out_mantissa=27'h4000000.
REQ-036 Zero and underflow:
- in_sum=0, exp=100 -> out_zero=1, exponent 0, mantissa 0.
- in_sum=28'h0000100, exp=5 -> out_exponent=0, out_mantissa=27'h0001000, out_underflow=1.
REQ-037 Overflow and Inf:
- Carry set, exp=254 -> out_exponent=255, mantissa 0, out_overflow=1.
- exp=255 with any in_sum -> pass-through, no flags.
REQ-038 Backpressure: stream 6 back-to-back items with out_ready=0 for cycles 3-6 -> all 6 arrive in order, outputs stable while stalled, in_ready=0 once both stages are full.
REQ-039 Reset mid-stream: rst pulsed with 2 items in flight -> out_valid=0 next cycle, outputs 0, and neither item emerges afterwards.
